// File: rtl/reorder_buffer.sv
// 16-entry in-order reorder buffer: tag allocation, CDB capture, in-order commit
// and register-status maintenance. Define ROB_FLUSH_EN to enable the flush sweep.
module reorder_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issueValid,
    output logic        issueReady,
    input  logic        issueHasDest,
    input  logic [4:0]  issueDest,
    output logic [5:0]  issueTag,
    output logic        statusWe,
    output logic [4:0]  statusIndex,
    output logic [5:0]  statusData,
    output logic [4:0]  queryIndex,
    input  logic [5:0]  queryStatus,
    input  logic        cdbValid,
    input  logic [5:0]  cdbTag,
    input  logic [31:0] cdbValue,
    output logic        commitValid,
    output logic [4:0]  commitIndex,
    output logic [31:0] commitValue,
    input  logic        flush,
    output logic [4:0]  robCount
);
    localparam int          DEPTH       = 16;
    localparam logic [5:0]  INVALID_TAG = 6'b010000;

    typedef enum logic {RUN, FLUSH} state_t;
    state_t state;

    logic [DEPTH-1:0]       busy, rdy, hasdest;
    logic [DEPTH-1:0][4:0]  dest;
    logic [DEPTH-1:0][31:0] value;
    logic [3:0]             head, tail, tail_nx;
    logic [4:0]             count, count_nx;
    logic                   fire, iss_wr, head_ok, needclr, defer, pop, clr, do_flush;
`ifdef ROB_FLUSH_EN
    logic [5:0]             fcnt;
    assign do_flush = flush;
`else
    logic                   unused_flush;
    assign unused_flush = flush;
    assign do_flush     = 1'b0;
`endif

    assign queryIndex = dest[head];

    always_comb begin
        fire     = issueValid && issueReady;
        iss_wr   = fire && issueHasDest;
        head_ok  = (state == RUN) && busy[head] && rdy[head];
        needclr  = hasdest[head] && (queryStatus == {2'b00, head});
        // Only one status write per cycle: an issue write to another register stalls the pop.
        defer    = head_ok && needclr && iss_wr && (dest[head] != issueDest);
        pop      = head_ok && !defer;
        clr      = pop && needclr && !iss_wr;
        tail_nx  = tail + 4'(fire);
        count_nx = count + 5'(fire) - 5'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            busy        <= '0;
            rdy         <= '0;
            hasdest     <= '0;
            dest        <= '0;
            value       <= '0;
            issueReady  <= 1'b1;
            issueTag    <= '0;
            statusWe    <= 1'b0;
            statusIndex <= '0;
            statusData  <= INVALID_TAG;
            commitValid <= 1'b0;
            commitIndex <= '0;
            commitValue <= '0;
            robCount    <= '0;
`ifdef ROB_FLUSH_EN
            fcnt        <= '0;
`endif
        end else if (do_flush) begin
`ifdef ROB_FLUSH_EN
            state       <= FLUSH;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            busy        <= '0;
            rdy         <= '0;
            hasdest     <= '0;
            issueReady  <= 1'b0;
            issueTag    <= '0;
            robCount    <= '0;
            commitValid <= 1'b0;
            statusWe    <= 1'b1;
            statusIndex <= '0;
            statusData  <= INVALID_TAG;
            fcnt        <= 6'd1;
`endif
        end else if (state == FLUSH) begin
`ifdef ROB_FLUSH_EN
            commitValid <= 1'b0;
            if (fcnt == 6'd32) begin
                state      <= RUN;
                statusWe   <= 1'b0;
                issueReady <= 1'b1;
            end else begin
                statusWe    <= 1'b1;
                statusIndex <= fcnt[4:0];
                statusData  <= INVALID_TAG;
                fcnt        <= fcnt + 6'd1;
            end
`endif
        end else begin
            statusWe    <= 1'b0;
            commitValid <= 1'b0;
            if (cdbValid && (cdbTag[5:4] == 2'b00) && busy[cdbTag[3:0]] && !rdy[cdbTag[3:0]]) begin
                rdy[cdbTag[3:0]]   <= 1'b1;
                value[cdbTag[3:0]] <= cdbValue;
            end
            if (pop) begin
                busy[head]  <= 1'b0;
                rdy[head]   <= 1'b0;
                head        <= head + 4'd1;
                commitValid <= hasdest[head];
                if (hasdest[head]) begin
                    commitIndex <= dest[head];
                    commitValue <= value[head];
                end
            end
            if (fire) begin
                busy[tail]    <= 1'b1;
                rdy[tail]     <= 1'b0;
                hasdest[tail] <= issueHasDest;
                dest[tail]    <= issueDest;
                tail          <= tail_nx;
            end
            if (iss_wr) begin
                statusWe    <= 1'b1;
                statusIndex <= issueDest;
                statusData  <= {2'b00, tail};
            end else if (clr) begin
                statusWe    <= 1'b1;
                statusIndex <= dest[head];
                statusData  <= INVALID_TAG;
            end
            count      <= count_nx;
            robCount   <= count_nx;
            issueReady <= (count_nx != 5'd16);
            issueTag   <= (count_nx == 5'd16) ? INVALID_TAG : {2'b00, tail_nx};
        end
    end
endmodule
